// File: rtl/prism_sp_puzzle_hw_gem_source_if.sv
// Write side of the GEM cookie FIFO: one-cycle write strobe, data word,
// and the FIFO's full flag coming back to the producer.
interface fifo_write_interface;
  logic        wr_en;
  logic [31:0] din;
  logic        full;

  modport master (
    output wr_en,
    output din,
    input  full
  );

  modport slave (
    input  wr_en,
    input  din,
    output full
  );
endinterface

// File: rtl/prism_sp_puzzle_hw_gem_source.sv
// GEM cookie producer: turns frame-completion events into 32-bit cookies
// {seq, err, 9'b0, len}, buffers them in a small circular queue and writes
// them into the cookie FIFO with single-cycle wr_en pulses.
//
// state            | meaning
// -----------------|-------------------------------------------------------
// STATE_FETCH_SLOT | idle; launches a write when a cookie is queued and the
//                  | FIFO is not full
// STATE_FIFO_CYCLE | settle cycle after a write; the written entry leaves
//                  | the queue here and full gets a cycle to update
module prism_sp_puzzle_hw_gem_source #(
  parameter int PENDING_DEPTH = 4
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            enable,
  input  logic                            frame_done,
  input  logic [13:0]                     frame_len,
  input  logic                            frame_err,
  fifo_write_interface.master             o_cookie_fifo_w,
  output logic [$clog2(PENDING_DEPTH):0]  pending_level,
  output logic [15:0]                     drop_count
);

  localparam int AW = $clog2(PENDING_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(PENDING_DEPTH);

  typedef enum logic {
    STATE_FETCH_SLOT = 1'b0,
    STATE_FIFO_CYCLE = 1'b1
  } state_t;

  // Queue entry layout: [22:15] seq, [14] err, [13:0] len
  logic [22:0]   r_mem [PENDING_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [LW-1:0] r_level;
  logic [7:0]    r_seq;
  logic [15:0]   r_drop_count;
  state_t        r_state;
  logic          r_wr_en;
  logic [31:0]   r_din;

  logic          w_full;
  logic          w_capture;
  logic          w_queue_full;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_launch;
  logic [22:0]   w_head_entry;
  logic [31:0]   w_head_cookie;

  assign w_full       = o_cookie_fifo_w.full;
  assign w_capture    = frame_done && enable;
  // Full test is against the level at the start of the cycle, so a pop
  // happening in the same cycle never makes room for the incoming frame.
  assign w_queue_full = (r_level == DEPTH_L);
  assign w_push       = w_capture && !w_queue_full;
  assign w_drop       = w_capture &&  w_queue_full;
  // The entry being written stays counted in the level until the settle
  // cycle, so pending_level drops one cycle after the wr_en pulse.
  assign w_pop        = (r_state == STATE_FIFO_CYCLE);
  assign w_launch     = (r_state == STATE_FETCH_SLOT) && (r_level != '0) && !w_full;

  assign w_head_entry  = r_mem[r_head];
  assign w_head_cookie = {w_head_entry[22:15], w_head_entry[14], 9'b0, w_head_entry[13:0]};

  assign o_cookie_fifo_w.wr_en = r_wr_en;
  assign o_cookie_fifo_w.din   = r_din;
  assign pending_level         = r_level;
  assign drop_count            = r_drop_count;

  // Queue storage: capture the new cookie at the tail slot (no reset needed,
  // validity is tracked by the pointers and level).
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_tail] <= {r_seq, frame_err, frame_len};
    end
  end

  // Queue pointers and occupancy; push and pop in the same cycle cancel.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sequence numbering of accepted frames and saturating drop counter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_seq        <= 8'd0;
      r_drop_count <= 16'd0;
    end else begin
      if (w_push) begin
        r_seq <= r_seq + 8'd1;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // Write FSM: one-cycle wr_en per cookie, followed by a settle cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= STATE_FETCH_SLOT;
      r_wr_en <= 1'b0;
      r_din   <= 32'd0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        STATE_FETCH_SLOT: begin
          if (w_launch) begin
            r_wr_en <= 1'b1;
            r_din   <= w_head_cookie;
            r_state <= STATE_FIFO_CYCLE;
          end
        end
        STATE_FIFO_CYCLE: begin
          r_state <= STATE_FETCH_SLOT;
        end
        default: begin
          r_state <= STATE_FETCH_SLOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prism_sp_puzzle_hw_gem_source.sv
// Testbench for the GEM cookie producer: a directed vector table, hand
// sequences for the multi-cycle corners, and random traffic against a
// queue-based reference model.
module tb_prism_sp_puzzle_hw_gem_source;

  localparam int DEPTH = 4;

  logic        clock;
  logic        resetn;
  logic        enable;
  logic        frame_done;
  logic [13:0] frame_len;
  logic        frame_err;
  logic [2:0]  pending_level;
  logic [15:0] drop_count;

  fifo_write_interface fifo_if ();

  prism_sp_puzzle_hw_gem_source #(.PENDING_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .enable          (enable),
    .frame_done      (frame_done),
    .frame_len       (frame_len),
    .frame_err       (frame_err),
    .o_cookie_fifo_w (fifo_if),
    .pending_level   (pending_level),
    .drop_count      (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: list of cookies waiting (including the one being
  // written), plus whether a write went out on the previous edge.
  logic [31:0] mq [$];
  int          m_seq;
  int          m_drop;
  bit          m_inflight;
  bit          m_wr;
  logic [31:0] m_din;

  // Writes observed on the FIFO side
  logic [31:0] cap_din [$];
  int          cap_cyc [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] cookie(input int seq, input bit err, input int len);
    return (32'(seq % 256) << 24) | (32'(err) << 23) | 32'(len % 16384);
  endfunction

  task automatic model_edge(input bit rn, input bit fd, input bit en,
                            input logic [13:0] len, input bit err, input bit fl);
    int lvl;
    bit emit;
    if (!rn) begin
      mq.delete();
      m_seq      = 0;
      m_drop     = 0;
      m_inflight = 0;
      m_wr       = 0;
      m_din      = 32'd0;
    end else begin
      lvl  = mq.size();
      emit = !m_inflight && (lvl != 0) && !fl;
      if (emit) m_din = mq[0];
      m_wr = emit;
      if (fd && en) begin
        if (lvl < DEPTH) begin
          mq.push_back(cookie(m_seq, err, int'(len)));
          m_seq = (m_seq + 1) % 256;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
      if (m_inflight) void'(mq.pop_front());
      m_inflight = emit;
    end
  endtask

  // One clock: drive inputs, advance model at the edge, sample at negedge.
  task automatic step(input bit rn, input bit fd, input bit en,
                      input logic [13:0] len, input bit err, input bit fl);
    resetn       = rn;
    frame_done   = fd;
    enable       = en;
    frame_len    = len;
    frame_err    = err;
    fifo_if.full = fl;
    @(posedge clock);
    cyc++;
    model_edge(rn, fd, en, len, err, fl);
    @(negedge clock);
    if (fifo_if.wr_en === 1'b1) begin
      cap_din.push_back(fifo_if.din);
      cap_cyc.push_back(cyc);
    end
    check("wr_en", {31'd0, fifo_if.wr_en}, {31'd0, m_wr});
    check("din", fifo_if.din, m_din);
    check("pending_level", {29'd0, pending_level}, 32'(mq.size()));
    check("drop_count", {16'd0, drop_count}, 32'(m_drop));
  endtask

  task automatic idle(input int n, input bit fl);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 14'd0, 1'b0, fl);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 14'd0, 1'b0, 1'b0);
    cap_din.delete();
    cap_cyc.delete();
  endtask

  typedef struct packed {
    bit          fd;
    bit          en;
    logic [13:0] len;
    bit          err;
    bit          wr;
    logic [31:0] din;
    logic [2:0]  lvl;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int          k0;
    logic [31:0] c;

    // Enable gating, then a single frame and an error frame after it
    tbl[0] = '{1'b1, 1'b0, 14'h3FFF, 1'b0, 1'b0, 32'h0000_0000, 3'd0};
    tbl[1] = '{1'b1, 1'b0, 14'h0ABC, 1'b1, 1'b0, 32'h0000_0000, 3'd0};
    tbl[2] = '{1'b1, 1'b0, 14'h0001, 1'b0, 1'b0, 32'h0000_0000, 3'd0};
    tbl[3] = '{1'b1, 1'b1, 14'h05EE, 1'b0, 1'b0, 32'h0000_0000, 3'd1};
    tbl[4] = '{1'b0, 1'b1, 14'h0000, 1'b0, 1'b1, 32'h0000_05EE, 3'd1};
    tbl[5] = '{1'b0, 1'b1, 14'h0000, 1'b0, 1'b0, 32'h0000_05EE, 3'd0};
    tbl[6] = '{1'b1, 1'b1, 14'h0123, 1'b1, 1'b0, 32'h0000_05EE, 3'd1};
    tbl[7] = '{1'b0, 1'b1, 14'h0000, 1'b0, 1'b1, 32'h0180_0123, 3'd1};
    tbl[8] = '{1'b0, 1'b1, 14'h0000, 1'b0, 1'b0, 32'h0180_0123, 3'd0};

    resetn = 1'b0; enable = 1'b0; frame_done = 1'b0;
    frame_len = '0; frame_err = 1'b0; fifo_if.full = 1'b0;

    do_reset();
    do_reset();
    check("reset wr_en", {31'd0, fifo_if.wr_en}, 32'd0);
    check("reset din", fifo_if.din, 32'd0);
    check("reset level", {29'd0, pending_level}, 32'd0);
    check("reset drops", {16'd0, drop_count}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      step(1'b1, tbl[i].fd, tbl[i].en, tbl[i].len, tbl[i].err, 1'b0);
      check("tbl wr_en", {31'd0, fifo_if.wr_en}, {31'd0, tbl[i].wr});
      check("tbl din", fifo_if.din, tbl[i].din);
      check("tbl level", {29'd0, pending_level}, {29'd0, tbl[i].lvl});
      check("tbl drops", {16'd0, drop_count}, 32'd0);
    end
    idle(2, 1'b0);
    check("single frame pulses", 32'(cap_din.size()), 32'd2);

    // Burst into a full FIFO, then release
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 1'b1, 14'(i), 1'b0, 1'b1);
    check("burst level", {29'd0, pending_level}, 32'd4);
    check("burst drops", {16'd0, drop_count}, 32'd2);
    check("burst no writes", 32'(cap_din.size()), 32'd0);
    k0 = cyc + 1;
    idle(12, 1'b0);
    check("burst pulse count", 32'(cap_din.size()), 32'd4);
    if (cap_din.size() == 4) begin
      check("burst first pulse cyc", 32'(cap_cyc[0]), 32'(k0));
      for (int i = 0; i < 4; i++) begin
        check("burst cookie", cap_din[i], (32'(i) << 24) | 32'(i + 1));
        if (i > 0) check("burst spacing", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd2);
      end
    end
    check("burst drained", {29'd0, pending_level}, 32'd0);

    // Simultaneous push/pop with the queue full
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 14'(10 + i), 1'b0, 1'b1);
    check("pp level before", {29'd0, pending_level}, 32'd4);
    step(1'b1, 1'b1, 1'b1, 14'd99, 1'b0, 1'b0);
    check("pp dropped", {16'd0, drop_count}, 32'd1);
    check("pp write", {31'd0, fifo_if.wr_en}, 32'd1);
    check("pp din", fifo_if.din, 32'h0000_000A);
    idle(1, 1'b0);
    check("pp level after", {29'd0, pending_level}, 32'd3);
    idle(8, 1'b0);

    // Sequence wrap and error flag on the 257th frame
    do_reset();
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 1'b1, 1'b1, 14'(i + 1), (i == 256), 1'b0);
      idle(1, 1'b0);
    end
    idle(4, 1'b0);
    check("wrap count", 32'(cap_din.size()), 32'd257);
    check("wrap drops", {16'd0, drop_count}, 32'd0);
    if (cap_din.size() == 257) begin
      c = cap_din[255];
      check("cookie256 seq", {24'd0, c[31:24]}, 32'hFF);
      check("cookie256 err", {31'd0, c[23]}, 32'd0);
      c = cap_din[256];
      check("cookie257 seq", {24'd0, c[31:24]}, 32'h00);
      check("cookie257 err", {31'd0, c[23]}, 32'd1);
      check("cookie257 len", {18'd0, c[13:0]}, 32'd257);
    end

    // Reset in the middle of a blocked burst
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 14'(20 + i), 1'b0, 1'b1);
    check("rst pre drops", {16'd0, drop_count}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 14'd0, 1'b0, 1'b1);
    check("rst wr_en", {31'd0, fifo_if.wr_en}, 32'd0);
    check("rst level", {29'd0, pending_level}, 32'd0);
    check("rst drops", {16'd0, drop_count}, 32'd0);
    cap_din.delete();
    cap_cyc.delete();
    step(1'b1, 1'b1, 1'b1, 14'h00AA, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("rst next count", 32'(cap_din.size()), 32'd1);
    if (cap_din.size() == 1) check("rst next cookie", cap_din[0], 32'h0000_00AA);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) != 0),
           ($urandom_range(1) == 1),
           ($urandom_range(9) != 0),
           14'($urandom),
           ($urandom_range(3) == 0),
           ($urandom_range(9) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
